// File: rtl/iq_sample_pacer.sv
// iq_sample_pacer: buffers 17-bit signed I/Q samples in a small FIFO and
// releases one reduced {I[15:0], Q[15:0]} word per pacing period to sync_short.
// Optional build macro: IQ_PACER_ROUND_SAT_EN selects round-half-up plus
// saturation for the 17->16 bit reduction; when undefined, plain truncation.
module iq_sample_pacer #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic [7:0]        strobe_period,
   input  logic [16:0]       in_i,
   input  logic [16:0]       in_q,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [31:0]       sample_out,
   output logic              sample_out_strobe,
   output logic [ADDR_W:0]   fifo_level,
   output logic              overflow,
   output logic              underrun
);

   localparam int unsigned SAMPLE_W = 17;
   localparam int unsigned ENTRY_W  = 2 * SAMPLE_W;
   localparam int unsigned HALF_W   = 16;
   localparam int unsigned PERIOD_W = 8;
   localparam int unsigned LEVEL_W  = ADDR_W + 1;

   // Reduce one 17-bit signed component to 16 bits.
   function automatic logic [HALF_W-1:0] reduce_f(input logic [SAMPLE_W-1:0] x);
`ifdef IQ_PACER_ROUND_SAT_EN
      logic [SAMPLE_W:0]   sum;
      logic [SAMPLE_W-1:0] r;
      sum = {x[SAMPLE_W-1], x} + (SAMPLE_W+1)'(1);
      r   = SAMPLE_W'(sum >> 1);
      if (r[SAMPLE_W-1] != r[HALF_W-1]) begin
         reduce_f = r[SAMPLE_W-1] ? 16'h8000 : 16'h7FFF;
      end else begin
         reduce_f = r[HALF_W-1:0];
      end
`else
      reduce_f = HALF_W'(x >> 1);
`endif
   endfunction

   logic [ENTRY_W-1:0]  mem_q [DEPTH];
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LEVEL_W-1:0]  count_q, count_d;
   logic [PERIOD_W-1:0] pace_q, pace_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [31:0]         out_q, out_d;
   logic                strobe_q, strobe_d;
   logic                ovf_q, ovf_d;
   logic                und_q, und_d;

   logic [PERIOD_W-1:0] period_clamped_c;
   logic [ENTRY_W-1:0]  head_c;
   logic                full_c;
   logic                push_c;
   logic                term_c;
   logic                pop_c;

   // Handshake, pacing slot and pop qualification from registered state.
   always_comb begin
      period_clamped_c = (strobe_period == '0) ? PERIOD_W'(1) : strobe_period;
      full_c           = (count_q == LEVEL_W'(DEPTH));
      push_c           = in_valid && !full_c;
      term_c           = enable && (pace_q == (period_q - PERIOD_W'(1)));
      pop_c            = term_c && (count_q != '0);
      head_c           = mem_q[rd_ptr_q];
   end

   // Next-state for pointers, level, pacing counter, output word and flags.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      pace_d   = pace_q;
      period_d = period_q;
      out_d    = out_q;
      strobe_d = 1'b0;
      ovf_d    = ovf_q;
      und_d    = und_q;

      if (push_c) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (in_valid && full_c) begin
         ovf_d = 1'b1;
      end

      if (!enable) begin
         pace_d = '0;
      end else if (term_c) begin
         pace_d   = '0;
         period_d = period_clamped_c;
      end else begin
         pace_d = pace_q + PERIOD_W'(1);
      end

      if (pop_c) begin
         out_d    = {reduce_f(head_c[ENTRY_W-1:SAMPLE_W]), reduce_f(head_c[SAMPLE_W-1:0])};
         strobe_d = 1'b1;
         rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end else if (term_c) begin
         und_d = 1'b1;
      end

      case ({push_c, pop_c})
         2'b10:   count_d = count_q + LEVEL_W'(1);
         2'b01:   count_d = count_q - LEVEL_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         pace_q   <= '0;
         period_q <= period_clamped_c;
         out_q    <= '0;
         strobe_q <= 1'b0;
         ovf_q    <= 1'b0;
         und_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         pace_q   <= pace_d;
         period_q <= period_d;
         out_q    <= out_d;
         strobe_q <= strobe_d;
         ovf_q    <= ovf_d;
         und_q    <= und_d;
      end
   end

   // Sample storage; contents need no reset since the level gates every read.
   always_ff @(posedge clock) begin
      if (!reset && push_c) begin
         mem_q[wr_ptr_q] <= {in_i, in_q};
      end
   end

   assign in_ready          = !full_c;
   assign sample_out        = out_q;
   assign sample_out_strobe = strobe_q;
   assign fifo_level        = count_q;
   assign overflow          = ovf_q;
   assign underrun          = und_q;

endmodule

// File: tb/tb_iq_sample_pacer.sv
// Randomised bench for iq_sample_pacer against a queue-based reference model.
module tb_iq_sample_pacer;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned ADDR_W = 4;

   logic              clock;
   logic              reset;
   logic              enable;
   logic [7:0]        strobe_period;
   logic [16:0]       in_i;
   logic [16:0]       in_q;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       sample_out;
   logic              sample_out_strobe;
   logic [ADDR_W:0]   fifo_level;
   logic              overflow;
   logic              underrun;

   iq_sample_pacer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clock             (clock),
      .reset             (reset),
      .enable            (enable),
      .strobe_period     (strobe_period),
      .in_i              (in_i),
      .in_q              (in_q),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .sample_out        (sample_out),
      .sample_out_strobe (sample_out_strobe),
      .fifo_level        (fifo_level),
      .overflow          (overflow),
      .underrun          (underrun)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Reference model state: stored samples as a queue plus pacing bookkeeping.
   logic [33:0] mq[$];
   int          m_clocks;
   int          m_period;
   logic [31:0] m_out;
   bit          m_stb;
   bit          m_ovf;
   bit          m_und;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Arithmetic reduction of a signed 17-bit value to 16 bits.
   function automatic logic [15:0] ref_reduce(input logic [16:0] x);
      int v;
      v = int'($signed(x));
`ifdef IQ_PACER_ROUND_SAT_EN
      v = (v + 1) >>> 1;
      if (v > 32767)  v = 32767;
      if (v < -32768) v = -32768;
`else
      v = v >>> 1;
`endif
      return 16'(v);
   endfunction

   function automatic int clamp_period(input logic [7:0] p);
      return (p == 8'd0) ? 1 : int'(p);
   endfunction

   // Advance model by one clock using current inputs, then compare DUT.
   task automatic cycle();
      int   lvl;
      bit   slot;
      logic [33:0] e;
      if (reset) begin
         mq.delete();
         m_clocks = 0;
         m_period = clamp_period(strobe_period);
         m_out    = '0;
         m_stb    = 1'b0;
         m_ovf    = 1'b0;
         m_und    = 1'b0;
      end else begin
         lvl   = mq.size();
         slot  = enable && (m_clocks + 1 == m_period);
         m_stb = 1'b0;
         if (!enable) m_clocks = 0;
         else if (slot) begin
            m_clocks = 0;
            m_period = clamp_period(strobe_period);
         end else m_clocks++;
         if (slot) begin
            if (lvl > 0) begin
               e     = mq.pop_front();
               m_out = {ref_reduce(e[33:17]), ref_reduce(e[16:0])};
               m_stb = 1'b1;
            end else begin
               m_und = 1'b1;
            end
         end
         if (in_valid) begin
            if (lvl < DEPTH) mq.push_back({in_i, in_q});
            else m_ovf = 1'b1;
         end
      end
      @(posedge clock);
      #1;
      check_val("level",     32'(fifo_level),        32'(mq.size()));
      check_val("in_ready",  32'(in_ready),          32'(mq.size() != DEPTH));
      check_val("strobe",    32'(sample_out_strobe), 32'(m_stb));
      check_val("sample",    sample_out,             m_out);
      check_val("overflow",  32'(overflow),          32'(m_ovf));
      check_val("underrun",  32'(underrun),          32'(m_und));
   endtask

   task automatic do_reset(input logic [7:0] sp);
      reset         = 1'b1;
      strobe_period = sp;
      in_valid      = 1'b0;
      cycle();
      reset = 1'b0;
   endtask

   task automatic push(input logic [16:0] i, input logic [16:0] q);
      in_valid = 1'b1;
      in_i     = i;
      in_q     = q;
      cycle();
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int k = 0; k < n; k++) cycle();
   endtask

   initial begin
      bit          seen;
      int          nstb;
      logic [31:0] exp_first;
      reset = 1'b0; enable = 1'b1; strobe_period = 8'd5;
      in_i = '0; in_q = '0; in_valid = 1'b0;
      m_clocks = 0; m_period = 1; m_out = '0; m_stb = 0; m_ovf = 0; m_und = 0;

      // Single sample, then underrun at the following slot.
      do_reset(8'd5);
      push(17'd3, 17'h1FFFD);
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
         cycle();
         if (sample_out_strobe) seen = 1'b1;
      end
`ifdef IQ_PACER_ROUND_SAT_EN
      exp_first = 32'h0002_FFFF;
`else
      exp_first = 32'h0001_FFFE;
`endif
      check_val("first_strobe_seen", 32'(seen), 32'd1);
      check_val("first_sample", sample_out, exp_first);
      idle(6);
      check_val("underrun_after_drain", 32'(underrun), 32'd1);

      // Overfill at the slowest pace, then drain.
      do_reset(8'd255);
      for (int k = 0; k < 20; k++) push(17'($urandom), 17'($urandom));
      check_val("full_level", 32'(fifo_level), 32'd16);
      check_val("full_ready", 32'(in_ready), 32'd0);
      check_val("full_overflow", 32'(overflow), 32'd1);
      nstb = 0;
      for (int k = 0; k < 16 * 255 + 100; k++) begin
         cycle();
         if (sample_out_strobe) nstb++;
      end
      check_val("drain_count", 32'(nstb), 32'd16);

      // Steady stream at period 5, then switch to 3 mid-run.
      do_reset(8'd5);
      for (int k = 0; k < 80; k++) begin
         in_valid = ($urandom % 4) != 0;
         in_i = 17'($urandom); in_q = 17'($urandom);
         cycle();
      end
      strobe_period = 8'd3;
      for (int k = 0; k < 70; k++) begin
         in_valid = ($urandom % 3) != 0;
         in_i = 17'($urandom); in_q = 17'($urandom);
         cycle();
      end
      in_valid = 1'b0;

      // Period 0 behaves as 1; extreme values exercise saturation.
      do_reset(8'd0);
      push(17'h0FFFF, 17'h10000);
      push(17'h10000, 17'h0FFFF);
      push(17'h1FFFF, 17'h00001);
      for (int k = 0; k < 5; k++) push(17'($urandom), 17'($urandom));
      idle(10);

      // Enable held low with four samples queued.
      do_reset(8'd4);
      enable = 1'b0;
      for (int k = 0; k < 4; k++) push(17'($urandom), 17'($urandom));
      idle(50);
      check_val("hold_level", 32'(fifo_level), 32'd4);
      check_val("hold_underrun", 32'(underrun), 32'd0);
      enable = 1'b1;
      idle(30);

      // Reset while half full.
      do_reset(8'd200);
      for (int k = 0; k < 8; k++) push(17'($urandom), 17'($urandom));
      in_valid = 1'b1;
      do_reset(8'd200);
      check_val("rst_level", 32'(fifo_level), 32'd0);
      check_val("rst_ready", 32'(in_ready), 32'd1);
      check_val("rst_flags", 32'({overflow, underrun}), 32'd0);
      check_val("rst_sample", sample_out, 32'd0);
      idle(20);

      // Random soak.
      do_reset(8'd3);
      for (int k = 0; k < 2000; k++) begin
         reset         = ($urandom % 200) == 0;
         enable        = ($urandom % 10) != 0;
         strobe_period = 8'($urandom_range(0, 6));
         in_valid      = ($urandom % 2) == 0;
         in_i          = 17'($urandom);
         in_q          = 17'($urandom);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
